// File: rtl/io_bridge_pkg.sv
// Shared constants for the CPU/peripheral bridge: local-controller register
// offsets, interrupt line width and the default window base.
package io_bridge_pkg;
  localparam int          INT_W        = 6;
  localparam logic [31:0] DEF_BASE     = 32'h0000_7f00;
  localparam logic [31:0] LC_IMR_OFF   = 32'h0;
  localparam logic [31:0] LC_IPR_OFF   = 32'h4;
  localparam logic [31:0] LC_IMODE_OFF = 32'h8;

  typedef enum logic [1:0] {LC_NONE, LC_IMR, LC_IPR, LC_IMODE} lc_reg_e;
endpackage

// File: rtl/io_bridge_n_if.sv
// CPU-side data bus of the bridge: address/data/strobes in, read data,
// bus error and interrupt lines back to the pipeline.
interface io_bridge_n_if;
  import io_bridge_pkg::*;

  logic [31:0]      addr_cpu;
  logic [31:0]      din_cpu;
  logic             we_cpu;
  logic             re_cpu;
  logic [31:0]      dout_cpu;
  logic             bus_err;
  logic [INT_W-1:0] intq_cpu;

  modport master (output addr_cpu, din_cpu, we_cpu, re_cpu,
                  input  dout_cpu, bus_err, intq_cpu);
  modport slave  (input  addr_cpu, din_cpu, we_cpu, re_cpu,
                  output dout_cpu, bus_err, intq_cpu);
endinterface

// File: rtl/io_bridge_n_irq_ctrl.sv
// Local interrupt controller: per-source mask, pending latch and
// edge/level mode, producing the registered CPU interrupt lines.
module irq_ctrl
  import io_bridge_pkg::*;
#(
  parameter int NDEV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  lc_reg_e          reg_sel_i,
  input  logic [NDEV-1:0]  wdata_i,
  input  logic [NDEV-1:0]  irq_i,
  output logic [31:0]      rdata_o,
  output logic [INT_W-1:0] intq_o
);
  logic [NDEV-1:0]  imr_q, imr_d, imode_q, imode_d, ipr_q, ipr_d, prev_q, w1c;
  logic [INT_W-1:0] intq_q;

  always_comb begin
    imr_d   = imr_q;
    imode_d = imode_q;
    w1c     = '0;
    if (wr_en_i && reg_sel_i == LC_IMR)   imr_d   = wdata_i;
    if (wr_en_i && reg_sel_i == LC_IMODE) imode_d = wdata_i;
    if (wr_en_i && reg_sel_i == LC_IPR)   w1c     = wdata_i;
    // Edge sources: a new edge beats a same-cycle clear. Level sources track irq.
    ipr_d = (imode_q & ((irq_i & ~prev_q) | (ipr_q & ~w1c))) | (~imode_q & irq_i);
  end

  always_comb begin
    rdata_o = '0;
    case (reg_sel_i)
      LC_IMR:   rdata_o = 32'(imr_q);
      LC_IPR:   rdata_o = 32'(ipr_q);
      LC_IMODE: rdata_o = 32'(imode_q);
      default:  rdata_o = '0;
    endcase
  end

  // prev always follows irq, so a level-to-edge switch sees no stale edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imr_q   <= '0;
      imode_q <= '0;
      ipr_q   <= '0;
      prev_q  <= '0;
      intq_q  <= '0;
    end else begin
      imr_q   <= imr_d;
      imode_q <= imode_d;
      ipr_q   <= ipr_d;
      prev_q  <= irq_i;
      intq_q  <= INT_W'(ipr_q & imr_q);
    end
  end

  assign intq_o = intq_q;
endmodule

// File: rtl/io_bridge_n.sv
// CPU/peripheral bridge: decodes NDEV device windows plus a local interrupt
// controller window, routes writes combinationally, registers read data.
module io_bridge_n
  import io_bridge_pkg::*;
#(
  parameter int          NDEV     = 2,
  parameter logic [31:0] BASE     = DEF_BASE,
  parameter int          WIN_LOG2 = 4,
  parameter int          OFF_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  io_bridge_n_if.slave       bus,
  output logic [OFF_W-1:0]   dev_addr,
  output logic [31:0]        dev_wdata,
  output logic [NDEV-1:0]    dev_we,
  input  logic [NDEV*32-1:0] dev_rdata,
  input  logic [NDEV-1:0]    dev_irq
);
  if (NDEV < 1 || NDEV > INT_W || WIN_LOG2 < OFF_W + 2) begin : g_param_err
    $error("io_bridge_n: illegal NDEV/WIN_LOG2/OFF_W combination");
  end

  localparam logic [31:0] REGION_SZ = 32'((NDEV + 1) << WIN_LOG2);
  localparam logic [31:0] WIN_MASK  = 32'((1 << WIN_LOG2) - 1);

  logic [31:0] rel, win, off, rd_sel, lc_rdata, dout_q, dout_d;
  logic        in_region, aligned, lc_hit, berr_q, berr_d;
  lc_reg_e     lc_sel;

  assign rel       = bus.addr_cpu - BASE;
  assign in_region = (bus.addr_cpu >= BASE) && (rel < REGION_SZ);
  assign aligned   = (bus.addr_cpu[1:0] == 2'b00);
  assign win       = rel >> WIN_LOG2;
  assign off       = rel & WIN_MASK;
  assign lc_hit    = in_region && aligned && (win == 32'(NDEV));

  assign dev_addr  = bus.addr_cpu[OFF_W+1:2];
  assign dev_wdata = bus.din_cpu;

  always_comb begin
    lc_sel = LC_NONE;
    if (lc_hit) begin
      if (off == LC_IMR_OFF)        lc_sel = LC_IMR;
      else if (off == LC_IPR_OFF)   lc_sel = LC_IPR;
      else if (off == LC_IMODE_OFF) lc_sel = LC_IMODE;
    end
  end

  always_comb begin
    dev_we = '0;
    rd_sel = '0;
    if (in_region && aligned) begin
      if (lc_hit) rd_sel = lc_rdata;
      for (int k = 0; k < NDEV; k++) begin
        if (win == 32'(k)) begin
          dev_we[k] = bus.we_cpu;
          rd_sel    = dev_rdata[32*k +: 32];
        end
      end
    end
  end

  irq_ctrl #(.NDEV(NDEV)) u_irq (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (bus.we_cpu),
    .reg_sel_i (lc_sel),
    .wdata_i   (bus.din_cpu[NDEV-1:0]),
    .irq_i     (dev_irq),
    .rdata_o   (lc_rdata),
    .intq_o    (bus.intq_cpu)
  );

  // Read data holds between strobes; misses and misaligned reads load zero
  assign dout_d = bus.re_cpu ? rd_sel : dout_q;
  assign berr_d = (bus.we_cpu || bus.re_cpu) && in_region && !aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      berr_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      berr_q <= berr_d;
    end
  end

  assign bus.dout_cpu = dout_q;
  assign bus.bus_err  = berr_q;
endmodule

// File: tb/tb_io_bridge_n.sv
// Self-checking bench for io_bridge_n: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the bridge.
module tb_io_bridge_n;
  localparam int          NDEV = 2;
  localparam logic [31:0] BASE = 32'h0000_7f00;
  localparam int          WIN  = 16;

  logic               clk;
  logic               rst_n;
  logic [1:0]         dev_addr;
  logic [31:0]        dev_wdata;
  logic [NDEV-1:0]    dev_we;
  logic [NDEV*32-1:0] dev_rdata;
  logic [NDEV-1:0]    dev_irq;

  io_bridge_n_if bus();

  io_bridge_n #(.NDEV(NDEV), .BASE(BASE), .WIN_LOG2(4), .OFF_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_we    (dev_we),
    .dev_rdata (dev_rdata),
    .dev_irq   (dev_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_err;

  // Behavioural model state
  bit [5:0]  m_imr, m_ipr, m_imode, m_prev, m_intq;
  bit [31:0] m_dout;
  bit        m_berr;

  task automatic model_reset();
    m_imr = 0; m_ipr = 0; m_imode = 0; m_prev = 0; m_intq = 0;
    m_dout = 0; m_berr = 0;
  endtask

  task automatic drive(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] din);
    bus.we_cpu = we; bus.re_cpu = re; bus.addr_cpu = addr; bus.din_cpu = din;
  endtask

  function automatic logic [NDEV-1:0] exp_we();
    logic [31:0] a;
    a = bus.addr_cpu;
    if (bus.we_cpu && a >= BASE && a < BASE + NDEV*WIN && a[1:0] == 2'b00)
      return NDEV'(1 << ((a - BASE) / WIN));
    return '0;
  endfunction

  // Advance one clock: the model consumes the inputs present at the edge
  task automatic tick();
    logic [31:0] a;
    int unsigned rel, win, off;
    bit inr, al, lcw;
    bit [5:0] irq6, din6, nipr;
    a = bus.addr_cpu;
    rel = a - BASE;
    inr = (a >= BASE) && (rel < (NDEV + 1) * WIN);
    al = (a[1:0] == 2'b00);
    win = rel / WIN;
    off = rel % WIN;
    lcw = bus.we_cpu && inr && al && (win == NDEV);
    irq6 = 6'(dev_irq);
    din6 = 6'(bus.din_cpu[NDEV-1:0]);
    if (bus.re_cpu) begin
      m_dout = 0;
      if (inr && al) begin
        if (win < NDEV)   m_dout = dev_rdata[win*32 +: 32];
        else if (off == 0) m_dout = 32'(m_imr);
        else if (off == 4) m_dout = 32'(m_ipr);
        else if (off == 8) m_dout = 32'(m_imode);
      end
    end
    m_berr = (bus.we_cpu || bus.re_cpu) && inr && !al;
    m_intq = m_ipr & m_imr;
    for (int i = 0; i < 6; i++) begin
      if (m_imode[i]) nipr[i] = (irq6[i] && !m_prev[i]) || (m_ipr[i] && !(lcw && off == 4 && din6[i]));
      else            nipr[i] = irq6[i];
    end
    if (lcw && off == 0) m_imr = din6;
    if (lcw && off == 8) m_imode = din6;
    m_ipr = nipr;
    m_prev = irq6;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.dout_cpu !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", bus.dout_cpu); end
    n_cmp++; if (bus.bus_err !== 1'b0) begin n_err++; $display("FAIL reset_berr: got %b want 0", bus.bus_err); end
    n_cmp++; if (bus.intq_cpu !== 6'h0) begin n_err++; $display("FAIL reset_intq: got %h want 0", bus.intq_cpu); end
    drive(0, 1, 32'h7f20, 0); tick();
    n_cmp++; if (bus.dout_cpu !== 32'h0) begin n_err++; $display("FAIL reset_imr: got %h want 0", bus.dout_cpu); end
  endtask

  task automatic test_write();
    drive(1, 0, 32'h7f14, 32'hA5); #1;
    n_cmp++; if (dev_we !== 2'b10) begin n_err++; $display("FAIL wr_we: got %b want 10", dev_we); end
    n_cmp++; if (dev_addr !== 2'd1) begin n_err++; $display("FAIL wr_addr: got %0d want 1", dev_addr); end
    n_cmp++; if (dev_wdata !== 32'hA5) begin n_err++; $display("FAIL wr_data: got %h want a5", dev_wdata); end
    tick();
    n_cmp++; if (bus.bus_err !== 1'b0) begin n_err++; $display("FAIL wr_berr: got %b want 0", bus.bus_err); end
  endtask

  task automatic test_read();
    dev_rdata = {32'hdead_beef, 32'h0000_1234};
    drive(0, 1, 32'h7f04, 0); tick();
    n_cmp++; if (bus.dout_cpu !== 32'h1234) begin n_err++; $display("FAIL rd_data: got %h want 1234", bus.dout_cpu); end
    drive(0, 0, 32'h7f04, 0); dev_rdata = {32'h1, 32'h5555_0000}; tick(); tick();
    n_cmp++; if (bus.dout_cpu !== 32'h1234) begin n_err++; $display("FAIL rd_hold: got %h want 1234", bus.dout_cpu); end
    drive(0, 1, 32'h7f10, 0); tick();
    n_cmp++; if (bus.dout_cpu !== 32'h1) begin n_err++; $display("FAIL rd_dev1: got %h want 1", bus.dout_cpu); end
    drive(0, 1, 32'h9000, 0); tick();
    n_cmp++; if (bus.dout_cpu !== 32'h0) begin n_err++; $display("FAIL rd_miss: got %h want 0", bus.dout_cpu); end
  endtask

  task automatic test_misaligned();
    drive(1, 0, 32'h7f06, 32'h77); #1;
    n_cmp++; if (dev_we !== 2'b00) begin n_err++; $display("FAIL mis_we: got %b want 00", dev_we); end
    tick();
    drive(0, 0, 32'h0, 0);
    n_cmp++; if (bus.bus_err !== 1'b1) begin n_err++; $display("FAIL mis_berr: got %b want 1", bus.bus_err); end
    tick();
    n_cmp++; if (bus.bus_err !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got %b want 0", bus.bus_err); end
    drive(1, 0, 32'h8000, 32'h77); #1;
    n_cmp++; if (dev_we !== 2'b00) begin n_err++; $display("FAIL oor_we: got %b want 00", dev_we); end
    tick();
    n_cmp++; if (bus.bus_err !== 1'b0) begin n_err++; $display("FAIL oor_berr: got %b want 0", bus.bus_err); end
  endtask

  task automatic test_edge_irq();
    dev_irq = 0;
    drive(1, 0, 32'h7f28, 1); tick();
    drive(1, 0, 32'h7f20, 1); tick();
    drive(1, 0, 32'h7f24, 3); tick();
    drive(0, 0, 32'h0, 0); tick();
    dev_irq = 2'b01; tick();
    dev_irq = 2'b00;
    n_cmp++; if (bus.intq_cpu !== 6'h0) begin n_err++; $display("FAIL edge_lat1: got %h want 0", bus.intq_cpu); end
    tick();
    n_cmp++; if (bus.intq_cpu !== 6'h1) begin n_err++; $display("FAIL edge_set: got %h want 1", bus.intq_cpu); end
    drive(1, 0, 32'h7f24, 1); tick();
    drive(0, 0, 32'h0, 0); tick();
    n_cmp++; if (bus.intq_cpu !== 6'h0) begin n_err++; $display("FAIL edge_w1c: got %h want 0", bus.intq_cpu); end
    dev_irq = 2'b01; drive(1, 0, 32'h7f24, 1); tick();
    dev_irq = 2'b00; drive(0, 1, 32'h7f24, 0); tick();
    drive(0, 0, 32'h0, 0);
    n_cmp++; if (bus.dout_cpu !== 32'h1) begin n_err++; $display("FAIL edge_race_ipr: got %h want 1", bus.dout_cpu); end
    n_cmp++; if (bus.intq_cpu !== 6'h1) begin n_err++; $display("FAIL edge_race_intq: got %h want 1", bus.intq_cpu); end
  endtask

  task automatic test_level_mask();
    drive(1, 0, 32'h7f28, 0); tick();
    drive(1, 0, 32'h7f20, 0); tick();
    dev_irq = 2'b10; drive(0, 0, 32'h0, 0); tick();
    drive(0, 1, 32'h7f24, 0); tick();
    n_cmp++; if (bus.dout_cpu !== 32'h2) begin n_err++; $display("FAIL lvl_ipr: got %h want 2", bus.dout_cpu); end
    n_cmp++; if (bus.intq_cpu !== 6'h0) begin n_err++; $display("FAIL lvl_masked: got %h want 0", bus.intq_cpu); end
    drive(1, 0, 32'h7f20, 2); tick();
    drive(0, 0, 32'h0, 0); tick();
    n_cmp++; if (bus.intq_cpu !== 6'h2) begin n_err++; $display("FAIL lvl_unmask: got %h want 2", bus.intq_cpu); end
    dev_irq = 2'b00; tick();
    n_cmp++; if (bus.intq_cpu !== 6'h2) begin n_err++; $display("FAIL lvl_drop1: got %h want 2", bus.intq_cpu); end
    tick();
    n_cmp++; if (bus.intq_cpu !== 6'h0) begin n_err++; $display("FAIL lvl_drop2: got %h want 0", bus.intq_cpu); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = BASE + 4 * $urandom_range(0, 11);
      else if (r < 8) a = BASE + $urandom_range(0, 47);
      else if (r < 9) a = BASE - $urandom_range(1, 32);
      else            a = BASE + 48 + $urandom_range(0, 64);
      r = $urandom_range(0, 3);
      drive(r == 1, r == 2, a, $urandom);
      dev_rdata = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) dev_irq = dev_irq ^ NDEV'($urandom_range(1, 3));
      #1;
      n_cmp++; if (dev_we !== exp_we()) begin n_err++; $display("FAIL rnd_we: got %b want %b", dev_we, exp_we()); end
      n_cmp++; if (dev_addr !== a[3:2] || dev_wdata !== bus.din_cpu) begin n_err++; $display("FAIL rnd_route: got %0d/%h want %0d/%h", dev_addr, dev_wdata, a[3:2], bus.din_cpu); end
      tick();
      n_cmp++; if (bus.dout_cpu !== m_dout) begin n_err++; $display("FAIL rnd_dout: got %h want %h", bus.dout_cpu, m_dout); end
      n_cmp++; if (bus.bus_err !== m_berr) begin n_err++; $display("FAIL rnd_berr: got %b want %b", bus.bus_err, m_berr); end
      n_cmp++; if (bus.intq_cpu !== m_intq) begin n_err++; $display("FAIL rnd_intq: got %h want %h", bus.intq_cpu, m_intq); end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 32'h7f28, 0); tick();
    drive(1, 0, 32'h7f20, 3); tick();
    dev_irq = 2'b11; drive(0, 1, 32'h7f20, 0); tick(); tick();
    n_cmp++; if (bus.intq_cpu !== 6'h3) begin n_err++; $display("FAIL arst_pre: got %h want 3", bus.intq_cpu); end
    drive(1, 1, 32'h7f27, 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (bus.dout_cpu !== 32'h0) begin n_err++; $display("FAIL arst_dout: got %h want 0", bus.dout_cpu); end
    n_cmp++; if (bus.bus_err !== 1'b0) begin n_err++; $display("FAIL arst_berr: got %b want 0", bus.bus_err); end
    n_cmp++; if (bus.intq_cpu !== 6'h0) begin n_err++; $display("FAIL arst_intq: got %h want 0", bus.intq_cpu); end
    dev_irq = 2'b00; drive(0, 1, 32'h7f20, 0);
    #4 rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.dout_cpu !== 32'h0) begin n_err++; $display("FAIL arst_imr: got %h want 0", bus.dout_cpu); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    dev_irq = '0;
    dev_rdata = '0;
    drive(0, 0, 32'h0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_read();
    test_misaligned();
    test_edge_irq();
    test_level_mask();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
